// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C engines: FSM states and per-quarter SCL/SDA patterns.
// Each pattern lists quarters q0..q3 from MSB to LSB.
package i2c_pkg;

  localparam int QUARTERS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP
  } state_t;

  localparam logic [3:0] PAT_START_SCL = 4'b1110;
  localparam logic [3:0] PAT_START_SDA = 4'b1100;
  localparam logic [3:0] PAT_BIT_SCL   = 4'b0110;
  localparam logic [3:0] PAT_STOP_SCL  = 4'b0111;
  localparam logic [3:0] PAT_STOP_SDA  = 4'b0011;
  localparam logic [3:0] PAT_SDA_HIGH  = 4'b1111;
  localparam logic [3:0] PAT_SDA_LOW   = 4'b0000;

  function automatic logic pat_bit(input logic [3:0] pat, input logic [1:0] q);
    return pat[2'd3 - q];
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider: tick is high for one cycle every DIV enabled cycles.
// restart zeroes the count so the first tick lands DIV cycles after it.
module i2c_tick_gen #(
  parameter int DIV = 8192
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_multi_writer.sv
// I2C write engine: START, 1..NBYTES bytes with ACK slots, STOP on any subset of NLINES buses.
// One tick per quarter bit, 8+36*LEN ticks per transfer; I2C_NACK_ABORT_EN stops after a NACKed byte.
module i2c_multi_writer
  import i2c_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int NLINES = 2,
  parameter int DIV    = 8192
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         START,
  input  logic [$clog2(NBYTES+1)-1:0]  LEN,
  input  logic [NLINES-1:0]            LINESEL,
  input  logic [8*NBYTES-1:0]          DATA,
  input  logic [NLINES-1:0]            SDA_IN,
  output logic [NLINES-1:0]            SCL_OUT,
  output logic [NLINES-1:0]            SDA_OUT,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         NACK
);

  localparam int LW = $clog2(NBYTES + 1);
  localparam int DW = 8 * NBYTES;

  state_t            state, state_nxt;
  logic              start_q;
  logic [1:0]        qtr;
  logic [2:0]        bit_cnt;
  logic [LW-1:0]     bytes_left;
  logic [LW-1:0]     len_c;
  logic [DW-1:0]     shreg;
  logic [NLINES-1:0] sel_q;
  logic              tick, accept, qlast, last_byte, ack_hit, done_nxt;
  logic              scl_b, sda_b;

  assign len_c   = (LEN > LW'(NBYTES)) ? LW'(NBYTES) : LEN;
  assign accept  = START && !start_q && (state == ST_IDLE);
  assign qlast   = tick && (qtr == 2'(QUARTERS - 1));
  assign ack_hit = |(SDA_IN & sel_q);

`ifdef I2C_NACK_ABORT_EN
  assign last_byte = (bytes_left == LW'(1)) || NACK;
`else
  assign last_byte = (bytes_left == LW'(1));
`endif

  i2c_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (CLK),
    .rst_n   (RSTN),
    .restart (accept),
    .en      (state != ST_IDLE),
    .tick    (tick)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    scl_b     = 1'b1;
    sda_b     = 1'b1;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (len_c == '0) done_nxt  = 1'b1;
          else             state_nxt = ST_START;
        end
      end
      ST_START: begin
        scl_b = pat_bit(PAT_START_SCL, qtr);
        sda_b = pat_bit(PAT_START_SDA, qtr);
        if (qlast) state_nxt = ST_BIT;
      end
      ST_BIT: begin
        scl_b = pat_bit(PAT_BIT_SCL, qtr);
        sda_b = pat_bit(shreg[DW-1] ? PAT_SDA_HIGH : PAT_SDA_LOW, qtr);
        if (qlast && bit_cnt == 3'd7) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        scl_b = pat_bit(PAT_BIT_SCL, qtr);
        sda_b = pat_bit(PAT_SDA_HIGH, qtr);
        if (qlast) state_nxt = last_byte ? ST_STOP : ST_BIT;
      end
      ST_STOP: begin
        scl_b = pat_bit(PAT_STOP_SCL, qtr);
        sda_b = pat_bit(PAT_STOP_SDA, qtr);
        if (qlast) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Payload shifts left one bit per BIT state, so the next byte's MSB is always on top.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      start_q    <= 1'b1;
      DONE       <= 1'b0;
      NACK       <= 1'b0;
      qtr        <= '0;
      bit_cnt    <= '0;
      bytes_left <= '0;
      shreg      <= '0;
      sel_q      <= '0;
    end else begin
      start_q <= START;
      DONE    <= done_nxt;
      if (accept) begin
        shreg      <= DATA;
        sel_q      <= LINESEL;
        bytes_left <= len_c;
        NACK       <= 1'b0;
        qtr        <= '0;
        bit_cnt    <= '0;
      end else if (tick) begin
        qtr <= qtr + 2'd1;
        if (state == ST_BIT && qlast) begin
          shreg   <= {shreg[DW-2:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == ST_ACK && qtr == 2'd2 && ack_hit) NACK <= 1'b1;
        if (state == ST_ACK && qlast) bytes_left <= bytes_left - LW'(1);
      end
    end
  end

  assign BUSY    = (state != ST_IDLE);
  assign SCL_OUT = {NLINES{scl_b}} | ~sel_q;
  assign SDA_OUT = {NLINES{sda_b}} | ~sel_q;

endmodule

// File: tb/tb_i2c_multi_writer.sv
// Directed bench for i2c_multi_writer: per-quarter expected bus states queued from a reference waveform model.
module tb_i2c_multi_writer;

  localparam int NBYTES = 4;
  localparam int NLINES = 2;
  localparam int DIV    = 4;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        START;
  logic [2:0]  LEN;
  logic [1:0]  LINESEL;
  logic [31:0] DATA;
  logic [1:0]  SDA_IN;
  logic [1:0]  SCL_OUT;
  logic [1:0]  SDA_OUT;
  logic        BUSY;
  logic        DONE;
  logic        NACK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] scl;
    logic [1:0] sda;
    logic       nack;
  } exp_t;

  exp_t       q_exp[$];
  logic [1:0] q_drv[$];

  always #5 CLK = ~CLK;

  i2c_multi_writer #(.NBYTES(NBYTES), .NLINES(NLINES), .DIV(DIV)) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .START   (START),
    .LEN     (LEN),
    .LINESEL (LINESEL),
    .DATA    (DATA),
    .SDA_IN  (SDA_IN),
    .SCL_OUT (SCL_OUT),
    .SDA_OUT (SDA_OUT),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .NACK    (NACK)
  );

  function automatic logic [6:0] stat();
    return {BUSY, DONE, NACK, SCL_OUT, SDA_OUT};
  endfunction

  task automatic check(input string tag, input int idx, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] busy/done/nack/scl/sda observed=%b required=%b", tag, idx, obs, exp);
    end
  endtask

  task automatic push_q(input logic [1:0] sel, input logic c, input logic d, input logic nk, input logic [1:0] drv);
    exp_t e;
    e.scl  = {2{c}} | ~sel;
    e.sda  = {2{d}} | ~sel;
    e.nack = nk;
    q_exp.push_back(e);
    q_drv.push_back(drv);
  endtask

  // nack_byte: index of the byte whose ACK slot sees nack_lines on SDA_IN (-1 for none).
  task automatic run_xfer(input int len, input logic [1:0] sel, input logic [31:0] data,
                          input int nack_byte, input logic [1:0] nack_lines,
                          input bit busy_pulse, input string tag);
    int         nb;
    int         k;
    logic       nk;
    logic       bt;
    logic [1:0] drv;
    logic [3:0] pscl;
    logic [3:0] psda;
    exp_t       e;
    nb = (len > NBYTES) ? NBYTES : len;
    nk = 1'b0;
    q_exp.delete();
    q_drv.delete();
    pscl = 4'b1110; psda = 4'b1100;
    for (int i = 3; i >= 0; i--) push_q(sel, pscl[i], psda[i], nk, 2'b00);
    for (int b = 0; b < nb; b++) begin
      pscl = 4'b0110;
      for (int j = 7; j >= 0; j--) begin
        bt = data[24 - 8*b + j];
        for (int i = 3; i >= 0; i--) push_q(sel, pscl[i], bt, nk, 2'b00);
      end
      drv = (b == nack_byte) ? nack_lines : 2'b00;
      for (int i = 3; i >= 0; i--) begin
        push_q(sel, pscl[i], 1'b1, nk, drv);
        if (i == 1 && (drv & sel) != 2'b00) nk = 1'b1;
      end
`ifdef I2C_NACK_ABORT_EN
      if (nk) break;
`endif
    end
    pscl = 4'b0111; psda = 4'b0011;
    for (int i = 3; i >= 0; i--) push_q(sel, pscl[i], psda[i], nk, 2'b00);

    START = 1'b0; LEN = 3'(len); LINESEL = sel; DATA = data;
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    k = 0;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      SDA_IN = q_drv.pop_front();
      check(tag, k, stat(), {1'b1, 1'b0, e.nack, e.scl, e.sda});
      if (busy_pulse) begin
        if (k == 5)      START = 1'b0;
        else if (k == 6) START = 1'b1;
        else if (k == 7) START = 1'b0;
      end
      k++;
      repeat (DIV) @(negedge CLK);
    end
    check({tag, "_done"}, k, stat(), {1'b0, 1'b1, nk, 2'b11, 2'b11});
    START  = 1'b0;
    SDA_IN = 2'b00;
    @(negedge CLK);
    check({tag, "_after"}, k + 1, stat(), {1'b0, 1'b0, nk, 2'b11, 2'b11});
  endtask

  initial begin
    RSTN = 1'b0; START = 1'b1; LEN = 3'd0; LINESEL = 2'b00; DATA = 32'h0; SDA_IN = 2'b00;
    repeat (3) @(negedge CLK);
    check("reset", 0, stat(), 7'b0001111);
    RSTN = 1'b1;
    repeat (3 * DIV) @(negedge CLK);
    check("start_held", 0, stat(), 7'b0001111);
    START = 1'b0;
    @(negedge CLK);

    run_xfer(2, 2'b10, 32'hA05C1234, -1, 2'b00, 1'b0, "xfer_a");
    run_xfer(2, 2'b10, 32'hA05C1234, 0, 2'b10, 1'b1, "nack_b");
    repeat (5) @(negedge CLK);
    check("nack_sticky", 0, stat(), 7'b0011111);

    START = 1'b0; LEN = 3'd0; LINESEL = 2'b11;
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("len0", 0, stat(), 7'b0101111);
    @(negedge CLK);
    check("len0", 1, stat(), 7'b0001111);
    START = 1'b0;
    repeat (2) @(negedge CLK);

    run_xfer(7, 2'b01, 32'h3CFF0081, -1, 2'b00, 1'b0, "clamp");
    run_xfer(1, 2'b01, 32'hF0000000, 0, 2'b10, 1'b0, "unsel_nack");
    run_xfer(1, 2'b00, 32'h55000000, 0, 2'b11, 1'b0, "nosel");

    START = 1'b0; LEN = 3'd2; LINESEL = 2'b11; DATA = 32'h00FF0000;
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    repeat (14 * DIV) @(negedge CLK);
    check("mid_bit", 0, {BUSY, DONE}, 7'b0000010);
    #1 RSTN = 1'b0;
    #1 check("mid_reset", 0, stat(), 7'b0001111);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    check("post_reset", 0, stat(), 7'b0001111);

    run_xfer(3, 2'b11, 32'h5AC39600, 2, 2'b01, 1'b0, "both");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
